// File: rtl/logicnet_pkg.sv
// Shared types and helpers for the LogicNet LUT layer.
// Holds the controller state encoding and table address width function.
package logicnet_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;

    function automatic int addr_width(input int fan_in, input int in_bits);
        return fan_in * in_bits;
    endfunction

endpackage

// File: rtl/logicnet_lut_ram.sv
// Single neuron truth table: one write port, one enabled registered read.
// Storage itself has no reset; only the read register is cleared.
module logicnet_lut_ram #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [DATA_W-1:0] rd_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read samples the pre-write contents when addresses collide.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_q <= '0;
        end else if (re_i) begin
            rd_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rd_q;

endmodule

// File: rtl/logicnet_lut_layer.sv
// Layer of runtime-loadable LUT neurons with a two-stage valid/ready pipe.
// Tables are zeroed by a sweep after reset before inputs are accepted.
module logicnet_lut_layer
    import logicnet_pkg::*;
#(
    parameter int N_NEURONS = 2,
    parameter int FAN_IN    = 4,
    parameter int IN_BITS   = 2,
    parameter int OUT_BITS  = 2,
    parameter int ADDR_W    = addr_width(FAN_IN, IN_BITS),
    parameter int NSEL_W    = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [N_NEURONS*ADDR_W-1:0]   in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [N_NEURONS*OUT_BITS-1:0] out_data,
    input  logic                          cfg_we,
    input  logic [NSEL_W-1:0]             cfg_neuron,
    input  logic [ADDR_W-1:0]             cfg_addr,
    input  logic [OUT_BITS-1:0]           cfg_data,
    output logic                          cfg_ready,
    output logic                          init_done
);

    state_e                        state_q, state_d;
    logic [ADDR_W-1:0]             clr_q, clr_d;
    logic                          s1_vld_q;
    logic [N_NEURONS*ADDR_W-1:0]   s1_dat_q;
    logic                          out_vld_q;

    logic                          run;
    logic                          clearing;
    logic                          adv;
    logic                          accept;
    logic                          cfg_fire;
    logic                          rd_en;
    logic [ADDR_W-1:0]             waddr;
    logic [OUT_BITS-1:0]           wdata;

    assign run       = (state_q == RUN);
    assign clearing  = (state_q == CLEAR);
    assign adv       = !out_vld_q || out_ready;
    assign in_ready  = run && !cfg_we && adv;
    assign cfg_ready = run;
    assign init_done = run;
    assign accept    = in_valid && in_ready;
    assign cfg_fire  = cfg_we && cfg_ready;
    assign rd_en     = adv && s1_vld_q;
    assign out_valid = out_vld_q;

    assign waddr = clearing ? clr_q : cfg_addr;
    assign wdata = clearing ? '0 : cfg_data;

    always_comb begin
        state_d = state_q;
        clr_d   = clr_q;
        unique case (state_q)
            CLEAR: begin
                clr_d = clr_q + ADDR_W'(1);
                if (clr_q == '1) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= CLEAR;
            clr_q     <= '0;
            s1_vld_q  <= 1'b0;
            s1_dat_q  <= '0;
            out_vld_q <= 1'b0;
        end else begin
            state_q <= state_d;
            clr_q   <= clr_d;
            if (adv) begin
                s1_vld_q  <= accept;
                out_vld_q <= s1_vld_q;
                if (accept) begin
                    s1_dat_q <= in_data;
                end
            end
        end
    end

    // Out-of-range neuron selects match no table and are dropped.
    for (genvar n = 0; n < N_NEURONS; n++) begin : g_neuron
        logic we_n;

        assign we_n = clearing
                   || (cfg_fire && (cfg_neuron == NSEL_W'(n)));

        logicnet_lut_ram #(
            .ADDR_W (ADDR_W),
            .DATA_W (OUT_BITS)
        ) u_ram (
            .clk_i   (clk),
            .rst_i   (rst),
            .we_i    (we_n),
            .waddr_i (waddr),
            .wdata_i (wdata),
            .re_i    (rd_en),
            .raddr_i (s1_dat_q[n*ADDR_W +: ADDR_W]),
            .rdata_o (out_data[n*OUT_BITS +: OUT_BITS])
        );
    end

endmodule

// File: tb/tb_logicnet_lut_layer.sv
// Self-checking bench for logicnet_lut_layer with a table-array model.
// Directed steps plus randomized streams checked through a result queue.
module tb_logicnet_lut_layer;

    localparam int NN = 2;
    localparam int AW = 8;
    localparam int OB = 2;
    localparam int DW = NN * AW;
    localparam int OW = NN * OB;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [OW-1:0] out_data;
    logic          cfg_we = 1'b0;
    logic [0:0]    cfg_neuron = '0;
    logic [AW-1:0] cfg_addr = '0;
    logic [OB-1:0] cfg_data = '0;
    logic          cfg_ready;
    logic          init_done;

    logic [OB-1:0] tbl [NN][256];
    logic [OW-1:0] exp_q [$];
    int total = 0;
    int bad = 0;
    int nres = 0;
    int cyc = 0;
    int or_mode = 0;
    bit last_acc = 0;

    always #5 clk = ~clk;

    logicnet_lut_layer dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .cfg_we     (cfg_we),
        .cfg_neuron (cfg_neuron),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .cfg_ready  (cfg_ready),
        .init_done  (init_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        total++;
        assert (obs === expv)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [OW-1:0] model(input logic [DW-1:0] a);
        logic [OW-1:0] r;
        r = '0;
        for (int n = 0; n < NN; n++) begin
            r[n*OB +: OB] = tbl[n][a[n*AW +: AW]];
        end
        return r;
    endfunction

    task automatic clear_model();
        for (int n = 0; n < NN; n++) begin
            for (int a = 0; a < 256; a++) begin
                tbl[n][a] = '0;
            end
        end
    endtask

    // One clock: observe handshakes before the edge, then re-drive.
    task automatic tick();
        #1;
        last_acc = in_valid && in_ready;
        if (last_acc) begin
            exp_q.push_back(model(in_data));
        end
        if (cfg_we && cfg_ready && (int'(cfg_neuron) < NN)) begin
            tbl[cfg_neuron][cfg_addr] = cfg_data;
        end
        if (out_valid && out_ready) begin
            nres++;
            chk("result_expected", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                chk("out_data", 32'(out_data), 32'(exp_q.pop_front()));
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (or_mode == 1) begin
            out_ready = (cyc % 3 == 0);
        end else if (or_mode == 2) begin
            out_ready = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic wait_init(input string tag);
        for (int i = 1; i <= 256; i++) begin
            tick();
            if (i == 128) begin
                chk({tag, "_cfg_ready_mid"}, 32'(cfg_ready), 0);
                chk({tag, "_in_ready_mid"}, 32'(in_ready), 0);
            end
            if (i == 255) begin
                chk({tag, "_early"}, 32'(init_done), 0);
            end
            if (i == 256) begin
                chk(tag, 32'(init_done), 1);
            end
        end
    endtask

    task automatic cfg_write(input int n, input int a, input int d);
        cfg_we = 1'b1;
        cfg_neuron = 1'(n);
        cfg_addr = AW'(a);
        cfg_data = OB'(d);
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic send(input logic [DW-1:0] d);
        in_valid = 1'b1;
        in_data = d;
        for (int k = 0; k < 50; k++) begin
            tick();
            if (last_acc) begin
                break;
            end
        end
        chk("send_accepted", 32'(last_acc), 1);
    endtask

    task automatic drain();
        in_valid = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (exp_q.size() == 0) begin
                break;
            end
            tick();
        end
        chk("drain_empty", exp_q.size(), 0);
    endtask

    function automatic logic [DW-1:0] rand_vec();
        logic [DW-1:0] v;
        for (int n = 0; n < NN; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                v[n*AW +: AW] = AW'($urandom_range(0, 255));
            end else begin
                v[n*AW +: AW] = AW'($urandom_range(0, 15));
            end
        end
        return v;
    endfunction

    initial begin
        int base;
        clear_model();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_cfg_ready", 32'(cfg_ready), 0);
        chk("rst_init_done", 32'(init_done), 0);
        rst = 1'b0;
        wait_init("init_256");

        in_valid = 1'b1;
        in_data = 16'h0000;
        tick();
        chk("acc_00", 32'(last_acc), 1);
        in_data = 16'hFFFF;
        tick();
        chk("acc_ff", 32'(last_acc), 1);
        in_valid = 1'b0;
        chk("lat_00", 32'(out_valid), 1);
        chk("val_00", 32'(out_data), 0);
        tick();
        chk("val_ff_valid", 32'(out_valid), 1);
        chk("val_ff", 32'(out_data), 0);
        drain();

        cfg_write(0, 8'h3C, 2'b11);
        cfg_write(1, 8'h3C, 2'b01);
        in_valid = 1'b1;
        in_data = 16'h3C3C;
        tick();
        in_valid = 1'b0;
        chk("cfg_lat1", 32'(out_valid), 0);
        tick();
        chk("cfg_lat2", 32'(out_valid), 1);
        chk("cfg_3c3c", 32'(out_data), 32'h7);
        drain();

        cfg_we = 1'b1;
        cfg_neuron = 1'b0;
        cfg_addr = 8'h55;
        cfg_data = 2'b10;
        in_valid = 1'b1;
        in_data = 16'h0055;
        #1;
        chk("prio_in_ready", 32'(in_ready), 0);
        tick();
        chk("prio_not_acc", 32'(last_acc), 0);
        cfg_we = 1'b0;
        tick();
        chk("prio_acc_next", 32'(last_acc), 1);
        in_valid = 1'b0;
        tick();
        chk("prio_valid", 32'(out_valid), 1);
        chk("prio_data", 32'(out_data), 32'h2);
        drain();

        for (int i = 0; i < 40; i++) begin
            cfg_write($urandom_range(0, NN - 1), $urandom_range(0, 15),
                      $urandom_range(0, 3));
        end
        base = nres;
        or_mode = 1;
        for (int i = 0; i < 10; i++) begin
            send(rand_vec());
        end
        drain();
        chk("stream10_count", nres - base, 10);

        or_mode = 2;
        base = nres;
        for (int i = 0; i < 60; i++) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, 2)) tick();
            send(rand_vec());
        end
        or_mode = 0;
        out_ready = 1'b1;
        drain();
        chk("stream60_count", nres - base, 60);

        out_ready = 1'b0;
        send(16'h3C3C);
        send(16'h0055);
        in_valid = 1'b0;
        chk("flight_valid", 32'(out_valid), 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 0);
        chk("mid_rst_out_data", 32'(out_data), 0);
        chk("mid_rst_in_ready", 32'(in_ready), 0);
        chk("mid_rst_cfg_ready", 32'(cfg_ready), 0);
        chk("mid_rst_init_done", 32'(init_done), 0);
        exp_q.delete();
        clear_model();
        out_ready = 1'b1;
        tick();
        rst = 1'b0;
        repeat (100) tick();
        chk("midclear_init", 32'(init_done), 0);
        rst = 1'b1;
        #1;
        chk("midclear_rst_cfg", 32'(cfg_ready), 0);
        tick();
        rst = 1'b0;
        wait_init("reinit_256");

        in_valid = 1'b1;
        in_data = 16'h3C3C;
        tick();
        in_valid = 1'b0;
        tick();
        chk("cleared_valid", 32'(out_valid), 1);
        chk("cleared_3c3c", 32'(out_data), 0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
